pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the in-order RV32I pipeline (IF/ID/EX/MEM/WB by default).
- Keeps a shadow scoreboard of the in-flight instructions that follow ID.
- Decides in the ID stage whether the instruction must stall, or which downstream result bus feeds each source operand once it reaches EX.
- Kills wrong-path instructions when EX resolves a taken branch or jump.

Parameters:
- REG_AW, 5, register-address width.
- TRACK_DEPTH, 3, number of tracked stages after ID (slot 0 = EX, slot TRACK_DEPTH-1 = WB); range 2..8.
- LOAD_READY, 2, first slot whose result bus carries load data (default: MEM/WB); range 1..TRACK_DEPTH-1.
- SEL_W, $clog2(TRACK_DEPTH+1), width of the forward selects (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_AW  source 1 of the ID instruction
- id_rs2  in  REG_AW  source 2 of the ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd  in  REG_AW  destination of the ID instruction
- id_wen  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- stall_if  out  1  hold the PC and IF/ID register
- stall_id  out  1  hold ID; insert a bubble into ID/EX
- flush_if  out  1  clear IF/ID to a bubble
- flush_id  out  1  clear ID/EX to a bubble
- ex_fwd_sel1  out  SEL_W  operand-1 source for the instruction now in EX: 0 = register file, k = result bus of slot k
- ex_fwd_sel2  out  SEL_W  operand-2 source, same encoding
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Scoreboard: slot[i] = {valid, rd, wen, is_load}. Each cycle slot[i] <= slot[i-1] for i ≥ 1.
- slot[0] <= ID instruction when it issues (id_valid & ~stall_id & ~ex_redirect); otherwise slot[0] <= bubble.
- A wen with rd == 0 is recorded as wen = 0.
- Match, per used source s with s != 0: the smallest i where slot[i].valid & wen & rd == s (youngest producer). No match or s == 0 gives "clear".
- Next cycle the producer sits at slot i+1. If i+1 ≥ TRACK_DEPTH, the value comes from the register file, which is write-through, so the select is 0.
- Hazard (forwarding build): the match is at slot i, slot[i].is_load, and i+1 < LOAD_READY. Otherwise the select is i+1.
- stall_if = stall_id = hazard on either source & id_valid & ~ex_redirect. This is combinational, in the same cycle.
- ex_redirect: flush_if = flush_id = 1 in the same cycle; stall is forced to 0 (the ID instruction is dead). Redirect has priority over the hazard.
- ex_fwd_sel1/2 are registered. They load the computed selects when the instruction issues and load 0 when a bubble enters slot 0 (stall, redirect or ~id_valid). This gives a latency of one cycle, aligned with the instruction entering EX.
- A load-use pair with defaults stalls exactly 1 cycle. A deeper pipe stalls LOAD_READY-1 cycles, re-evaluated every cycle until clear.
- stall_cnt increments on every cycle with stall_id = 1 and saturates at 0xFFFFFFFF.
- Reset: all slots invalid; ex_fwd_sel1/2 = 0; stall_cnt = 0. Stall and flush outputs are 0 while rst is high.
- Reset mid-stall: the stall drops in the cycle rst is asserted and the scoreboard empties.

Optional Feature:
- Macro: PIPELINE_HAZARD_FWD_EN.
- Defined: forwarding as above.
- Undefined: no forwarding; ex_fwd_sel1/2 are tied to 0. Any match at slot i < TRACK_DEPTH-1 stalls, whether the producer is a load or not. Defaults give up to a 2-cycle stall on back-to-back ALU ops.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants (OP_R 0110011, OP_I 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111)
  - slot_t struct {valid, rd, wen, is_load}
  - fwd-select encoding constants (FWD_RF = 0)
- Sub-module hazard_match: combinational priority finder, youngest matching slot plus a stall/select decision for one source. Instantiated twice, for rs1 and rs2.

Test Plan:
- add x5 issued, then add x6,x5,x0 next in ID → no stall; ex_fwd_sel1 = 1 the cycle after; stall_cnt = 0.
- lw x5 issued, then add x6,x5,x5 in ID → stall_id = 1 for exactly 1 cycle; after that ex_fwd_sel1 = ex_fwd_sel2 = 2; stall_cnt = 1.
- add x0,x1,x2 issued, then consumer reads x0 → no stall; select 0.
- lw x5 in EX and ex_redirect = 1 while a dependent instruction sits in ID → flush_if = flush_id = 1, stall_id = 0, slot[0] bubble next cycle, ex_fwd_sel = 0.
- Without PIPELINE_HAZARD_FWD_EN: add x5, then add x6,x5 → stall 2 cycles; selects stay 0; stall_cnt = 2.
- rst asserted during a load-use stall → stall_id = 0 that cycle; slots cleared; stall_cnt = 0; ex_fwd_sel1/2 = 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
// Holds the scoreboard slot layout, the forward-select encoding and the
// major opcodes the decode logic keys on.
package pipe_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The rd field is sized for the widest supported register address; narrower
  // address widths are zero-extended on entry, so a match is still exact.
  localparam int REG_AW_MAX = 8;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  wen;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/hazard_match.sv
// Priority finder for one source operand: locates the youngest in-flight
// producer of the register and turns its position into either a stall
// request or a forward select. Build option PIPELINE_HAZARD_FWD_EN selects
// the forwarding rules; without it every non-WB producer stalls.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int TRACK_DEPTH = 3,
  parameter int LOAD_READY  = 2,
  parameter int SEL_W       = $clog2(TRACK_DEPTH + 1)
) (
  input  slot_t [TRACK_DEPTH-1:0] slots,
  input  logic [REG_AW_MAX-1:0]   src,
  input  logic                    use_src,
  output logic                    hazard,
  output logic [SEL_W-1:0]        sel
);

  logic hit;
  logic hit_load;
  int   hit_idx;

  // Scan oldest to youngest so the last hit written is the youngest producer.
  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_idx  = 0;
    for (int i = TRACK_DEPTH - 1; i >= 0; i--) begin
      if (use_src && (src != '0) && slots[i].valid && slots[i].wen &&
          (slots[i].rd == src)) begin
        hit      = 1'b1;
        hit_load = slots[i].is_load;
        hit_idx  = i;
      end
    end
  end

`ifdef PIPELINE_HAZARD_FWD_EN
  // Next cycle the producer is one slot older; past the last slot the
  // write-through register file already holds the value.
  always_comb begin
    hazard = hit && hit_load && ((hit_idx + 1) < LOAD_READY);
    sel    = SEL_W'(FWD_RF);
    if (hit && ((hit_idx + 1) < TRACK_DEPTH)) begin
      sel = SEL_W'(hit_idx + 1);
    end
  end
`else
  logic unused_hit_load;
  assign unused_hit_load = hit_load;

  // Only the WB slot is safe: the register file writes through to ID.
  always_comb begin
    hazard = hit && (hit_idx < (TRACK_DEPTH - 1));
    sel    = SEL_W'(FWD_RF);
  end
`endif

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and flush controller for the in-order RV32I pipeline.
// Tracks the instructions issued past ID in a shift-register scoreboard,
// stalls ID on unresolved dependencies, registers the EX forward selects and
// flushes the front end on a taken EX redirect.
// Build option: define PIPELINE_HAZARD_FWD_EN to enable operand forwarding;
// without it the forward selects are tied to the register file.
module pipeline_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int TRACK_DEPTH = 3,
  parameter int LOAD_READY  = 2,
  parameter int SEL_W       = $clog2(TRACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_if,
  output logic              flush_id,
  output logic [SEL_W-1:0]  ex_fwd_sel1,
  output logic [SEL_W-1:0]  ex_fwd_sel2,
  output logic [31:0]       stall_cnt
);

  slot_t [TRACK_DEPTH-1:0] slots;
  slot_t                   id_entry;
  logic                    haz1, haz2;
  logic [SEL_W-1:0]        sel1, sel2;
  logic                    stall;
  logic                    issue;
  logic [31:0]             stall_cnt_p1;

  hazard_match #(
    .TRACK_DEPTH (TRACK_DEPTH),
    .LOAD_READY  (LOAD_READY),
    .SEL_W       (SEL_W)
  ) u_match_rs1 (
    .slots   (slots),
    .src     (REG_AW_MAX'(id_rs1)),
    .use_src (id_use_rs1),
    .hazard  (haz1),
    .sel     (sel1)
  );

  hazard_match #(
    .TRACK_DEPTH (TRACK_DEPTH),
    .LOAD_READY  (LOAD_READY),
    .SEL_W       (SEL_W)
  ) u_match_rs2 (
    .slots   (slots),
    .src     (REG_AW_MAX'(id_rs2)),
    .use_src (id_use_rs2),
    .hazard  (haz2),
    .sel     (sel2)
  );

  // Redirect kills the ID instruction, so it overrides any hazard; reset
  // silences all front-end control in the same cycle.
  always_comb begin
    stall    = ~rst & id_valid & ~ex_redirect & (haz1 | haz2);
    issue    = id_valid & ~stall & ~ex_redirect;
    id_entry.valid   = 1'b1;
    id_entry.rd      = REG_AW_MAX'(id_rd);
    id_entry.wen     = id_wen & (id_rd != '0);
    id_entry.is_load = id_is_load;
  end

  assign stall_if  = stall;
  assign stall_id  = stall;
  assign flush_if  = ~rst & ex_redirect;
  assign flush_id  = ~rst & ex_redirect;
  assign stall_cnt = stall_cnt_p1;

  // ID -> EX boundary: scoreboard shift and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots        <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      slots[0] <= issue ? id_entry : '0;
      for (int i = 1; i < TRACK_DEPTH; i++) begin
        slots[i] <= slots[i-1];
      end
      if (stall && (stall_cnt_p1 != 32'hFFFF_FFFF)) begin
        stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
      end
    end
  end

`ifdef PIPELINE_HAZARD_FWD_EN
  logic [SEL_W-1:0] sel1_p1, sel2_p1;

  // ID -> EX boundary: selects follow the instruction into EX; bubbles read RF.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel1_p1 <= SEL_W'(FWD_RF);
      sel2_p1 <= SEL_W'(FWD_RF);
    end else begin
      sel1_p1 <= issue ? sel1 : SEL_W'(FWD_RF);
      sel2_p1 <= issue ? sel2 : SEL_W'(FWD_RF);
    end
  end

  assign ex_fwd_sel1 = sel1_p1;
  assign ex_fwd_sel2 = sel2_p1;
`else
  logic unused_sel;
  assign unused_sel  = ^{sel1, sel2};
  assign ex_fwd_sel1 = SEL_W'(FWD_RF);
  assign ex_fwd_sel2 = SEL_W'(FWD_RF);
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit; expectations adapt to whether
// PIPELINE_HAZARD_FWD_EN is defined for the build.
module tb_pipeline_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_wen, id_is_load;
  logic        ex_redirect;
  logic        stall_if, stall_id, flush_if, flush_id;
  logic [1:0]  ex_fwd_sel1, ex_fwd_sel2;
  logic [31:0] stall_cnt;

  int vec  = 0;
  int errs = 0;

  pipeline_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_wen      (id_wen),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .ex_fwd_sel1 (ex_fwd_sel1),
    .ex_fwd_sel2 (ex_fwd_sel2),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic wen, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_wen = wen; id_is_load = ld;
  endtask

  task automatic idle();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_redirect = 1'b0; idle();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_redirect = 1'b1;
    drive_id(1, 5, 5, 1, 1, 6, 1, 0);
    tick(); tick();
    #1;
    vec++; if (flush_if !== 1'b0 || flush_id !== 1'b0) begin
      $display("FAIL reset_flush got %b%b want 00", flush_if, flush_id); errs++; end
    vec++; if (stall_id !== 1'b0 || stall_if !== 1'b0) begin
      $display("FAIL reset_stall got %b%b want 00", stall_if, stall_id); errs++; end
    vec++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0 || stall_cnt !== 32'd0) begin
      $display("FAIL reset_state got sel %0d/%0d cnt %0d want 0/0 0",
               ex_fwd_sel1, ex_fwd_sel2, stall_cnt); errs++; end
    rst = 1'b0; ex_redirect = 1'b0; idle();
    tick();
  endtask

  // add x5,x1,x2 then add x6,x5,x0
  task automatic test_alu_fwd();
    int exp_st; logic [1:0] exp_s1;
`ifdef PIPELINE_HAZARD_FWD_EN
    exp_st = 0; exp_s1 = 2'd1;
`else
    exp_st = 2; exp_s1 = 2'd0;
`endif
    do_reset();
    drive_id(1, 1, 2, 1, 1, 5, 1, 0);
    #1;
    vec++; if (stall_id !== 1'b0) begin
      $display("FAIL alu_producer_stall got %b want 0", stall_id); errs++; end
    tick();
    drive_id(1, 5, 0, 1, 1, 6, 1, 0);
    for (int c = 0; c <= exp_st; c++) begin
      #1;
      vec++; if (stall_id !== (c < exp_st) || stall_if !== (c < exp_st)) begin
        $display("FAIL alu_stall_c%0d got %b%b want %b", c, stall_if, stall_id, (c < exp_st));
        errs++; end
      tick();
    end
    idle();
    vec++; if (ex_fwd_sel1 !== exp_s1 || ex_fwd_sel2 !== 2'd0) begin
      $display("FAIL alu_sel got %0d/%0d want %0d/0", ex_fwd_sel1, ex_fwd_sel2, exp_s1); errs++; end
    vec++; if (stall_cnt !== 32'(exp_st)) begin
      $display("FAIL alu_cnt got %0d want %0d", stall_cnt, exp_st); errs++; end
  endtask

  // lw x5,0(x1) then add x6,x5,x5
  task automatic test_load_use();
    int exp_st; logic [1:0] exp_s;
`ifdef PIPELINE_HAZARD_FWD_EN
    exp_st = 1; exp_s = 2'd2;
`else
    exp_st = 2; exp_s = 2'd0;
`endif
    do_reset();
    drive_id(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive_id(1, 5, 5, 1, 1, 6, 1, 0);
    for (int c = 0; c <= exp_st; c++) begin
      #1;
      vec++; if (stall_id !== (c < exp_st)) begin
        $display("FAIL load_use_stall_c%0d got %b want %b", c, stall_id, (c < exp_st)); errs++; end
      vec++; if (ex_fwd_sel1 !== 2'd0) begin
        $display("FAIL load_use_bubble_sel_c%0d got %0d want 0", c, ex_fwd_sel1); errs++; end
      tick();
    end
    idle();
    vec++; if (ex_fwd_sel1 !== exp_s || ex_fwd_sel2 !== exp_s) begin
      $display("FAIL load_use_sel got %0d/%0d want %0d/%0d", ex_fwd_sel1, ex_fwd_sel2, exp_s, exp_s);
      errs++; end
    vec++; if (stall_cnt !== 32'(exp_st)) begin
      $display("FAIL load_use_cnt got %0d want %0d", stall_cnt, exp_st); errs++; end
  endtask

  // add x0,x1,x2 then a consumer of x0
  task automatic test_x0();
    do_reset();
    drive_id(1, 1, 2, 1, 1, 0, 1, 0);
    tick();
    drive_id(1, 0, 0, 1, 1, 6, 1, 0);
    #1;
    vec++; if (stall_id !== 1'b0) begin
      $display("FAIL x0_stall got %b want 0", stall_id); errs++; end
    tick();
    idle();
    vec++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0) begin
      $display("FAIL x0_sel got %0d/%0d want 0/0", ex_fwd_sel1, ex_fwd_sel2); errs++; end
  endtask

  // Two writers of x5 back-to-back; consumer must see the younger one.
  task automatic test_back_to_back();
    int exp_st; logic [1:0] exp_s2;
`ifdef PIPELINE_HAZARD_FWD_EN
    exp_st = 0; exp_s2 = 2'd1;
`else
    exp_st = 2; exp_s2 = 2'd0;
`endif
    do_reset();
    drive_id(1, 1, 0, 1, 0, 5, 1, 0);
    tick();
    drive_id(1, 2, 0, 1, 0, 5, 1, 0);
    #1;
    vec++; if (stall_id !== 1'b0) begin
      $display("FAIL b2b_second_writer_stall got %b want 0", stall_id); errs++; end
    tick();
    drive_id(1, 3, 5, 1, 1, 7, 1, 0);
    for (int c = 0; c <= exp_st; c++) begin
      #1;
      vec++; if (stall_id !== (c < exp_st)) begin
        $display("FAIL b2b_stall_c%0d got %b want %b", c, stall_id, (c < exp_st)); errs++; end
      tick();
    end
    idle();
    vec++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== exp_s2) begin
      $display("FAIL b2b_sel got %0d/%0d want 0/%0d", ex_fwd_sel1, ex_fwd_sel2, exp_s2); errs++; end
  endtask

  // Producer, one bubble, then consumer: producer sits at MEM.
  task automatic test_distance();
    int exp_st; logic [1:0] exp_s1;
`ifdef PIPELINE_HAZARD_FWD_EN
    exp_st = 0; exp_s1 = 2'd2;
`else
    exp_st = 1; exp_s1 = 2'd0;
`endif
    do_reset();
    drive_id(1, 1, 2, 1, 1, 5, 1, 0);
    tick();
    idle();
    tick();
    drive_id(1, 5, 0, 1, 0, 6, 1, 0);
    for (int c = 0; c <= exp_st; c++) begin
      #1;
      vec++; if (stall_id !== (c < exp_st)) begin
        $display("FAIL dist_stall_c%0d got %b want %b", c, stall_id, (c < exp_st)); errs++; end
      tick();
    end
    idle();
    vec++; if (ex_fwd_sel1 !== exp_s1) begin
      $display("FAIL dist_sel got %0d want %0d", ex_fwd_sel1, exp_s1); errs++; end
    vec++; if (stall_cnt !== 32'(exp_st)) begin
      $display("FAIL dist_cnt got %0d want %0d", stall_cnt, exp_st); errs++; end
  endtask

  // lw x5 enters EX while EX redirects and a dependent add sits in ID.
  task automatic test_redirect();
    do_reset();
    drive_id(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive_id(1, 5, 5, 1, 1, 6, 1, 0);
    ex_redirect = 1'b1;
    #1;
    vec++; if (flush_if !== 1'b1 || flush_id !== 1'b1) begin
      $display("FAIL redirect_flush got %b%b want 11", flush_if, flush_id); errs++; end
    vec++; if (stall_id !== 1'b0 || stall_if !== 1'b0) begin
      $display("FAIL redirect_stall got %b%b want 00", stall_if, stall_id); errs++; end
    tick();
    ex_redirect = 1'b0;
    drive_id(1, 6, 0, 1, 1, 7, 1, 0);
    #1;
    vec++; if (stall_id !== 1'b0) begin
      $display("FAIL redirect_killed_not_tracked got %b want 0", stall_id); errs++; end
    vec++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0) begin
      $display("FAIL redirect_sel got %0d/%0d want 0/0", ex_fwd_sel1, ex_fwd_sel2); errs++; end
    vec++; if (flush_if !== 1'b0 || stall_cnt !== 32'd0) begin
      $display("FAIL redirect_after got flush %b cnt %0d want 0 0", flush_if, stall_cnt); errs++; end
    idle();
    tick();
  endtask

  // Runs straight after test_load_use so the counter starts non-zero.
  task automatic test_reset_mid_stall();
    int prev;
`ifdef PIPELINE_HAZARD_FWD_EN
    prev = 1;
`else
    prev = 2;
`endif
    idle();
    tick(); tick(); tick();
    vec++; if (stall_cnt !== 32'(prev)) begin
      $display("FAIL rms_hold_cnt got %0d want %0d", stall_cnt, prev); errs++; end
    drive_id(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive_id(1, 5, 5, 1, 1, 6, 1, 0);
    #1;
    vec++; if (stall_id !== 1'b1) begin
      $display("FAIL rms_stall_before got %b want 1", stall_id); errs++; end
    rst = 1'b1;
    #1;
    vec++; if (stall_id !== 1'b0 || stall_if !== 1'b0) begin
      $display("FAIL rms_stall_drop got %b%b want 00", stall_if, stall_id); errs++; end
    tick();
    rst = 1'b0;
    #1;
    vec++; if (stall_id !== 1'b0) begin
      $display("FAIL rms_slots_cleared got stall %b want 0", stall_id); errs++; end
    vec++; if (stall_cnt !== 32'd0 || ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0) begin
      $display("FAIL rms_state got cnt %0d sel %0d/%0d want 0 0/0",
               stall_cnt, ex_fwd_sel1, ex_fwd_sel2); errs++; end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; idle();
    test_reset();
    test_alu_fwd();
    test_x0();
    test_back_to_back();
    test_distance();
    test_redirect();
    test_load_use();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
